// File: rtl/abacus_pkg.sv
// Shared types for the ABACUS multi-core trace hub.
// Optional feature macro: ABACUS_TRACE_TIMESTAMP_EN (adds a timestamp field to each entry).
package abacus_pkg;

  typedef enum logic [2:0] {
    EV_ISSUED          = 3'd0,
    EV_ICACHE_REQ      = 3'd1,
    EV_ICACHE_MISS     = 3'd2,
    EV_ICACHE_FILL_CYC = 3'd3,
    EV_DCACHE_REQ      = 3'd4,
    EV_DCACHE_HIT      = 3'd5,
    EV_DCACHE_FILL_CYC = 3'd6,
    EV_TRACE_DROP      = 3'd7
  } abacus_event_e;

  localparam int ABACUS_NUM_EVENTS = 8;

  // Timestamps are carried through the FIFOs at this width; the hub's TS_W may not exceed it.
  localparam int ABACUS_TS_W = 32;

  typedef struct packed {
`ifdef ABACUS_TRACE_TIMESTAMP_EN
    logic [ABACUS_TS_W-1:0] timestamp;
`endif
    logic [31:0]            instruction;
  } abacus_trace_entry_t;

endpackage

// File: rtl/abacus_trace_hub_if.sv
// Merged trace stream (valid/ready) leaving the ABACUS trace hub.
// Optional feature macro: ABACUS_TRACE_TIMESTAMP_EN (adds trace_timestamp).
interface abacus_trace_hub_if
  import abacus_pkg::*;
#(
  parameter int CORE_W = 1,
  parameter int TS_W   = ABACUS_TS_W
);

  logic              trace_valid;
  logic              trace_ready;
  logic [CORE_W-1:0] trace_core_id;
  logic [31:0]       trace_instruction;

  if (CORE_W < 1 || TS_W < 1) begin : g_bad_width
    $error("abacus_trace_hub_if: CORE_W and TS_W must be positive");
  end

`ifdef ABACUS_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]   trace_timestamp;

  modport master (output trace_valid, trace_core_id, trace_instruction, trace_timestamp,
                  input  trace_ready);
  modport slave  (input  trace_valid, trace_core_id, trace_instruction, trace_timestamp,
                  output trace_ready);
`else
  modport master (output trace_valid, trace_core_id, trace_instruction,
                  input  trace_ready);
  modport slave  (input  trace_valid, trace_core_id, trace_instruction,
                  output trace_ready);
`endif

endinterface

// File: rtl/abacus_trace_fifo.sv
// Single-clock circular FIFO holding one core's trace entries.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module abacus_trace_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/abacus_trace_hub.sv
// ABACUS multi-core profiling hub: per-core trace FIFOs merged round-robin onto one
// valid/ready stream, plus per-core saturating event counters behind a registered read port.
// Optional feature macro: ABACUS_TRACE_TIMESTAMP_EN (timestamps each entry at push).
module abacus_trace_hub
  import abacus_pkg::*;
#(
  parameter int NUM_CORES  = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32,
  parameter int TS_W       = ABACUS_TS_W,
  localparam int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_CORES*32-1:0] core_instruction,
  input  logic [NUM_CORES-1:0]   core_issued,
  input  logic [NUM_CORES-1:0]   core_icache_req,
  input  logic [NUM_CORES-1:0]   core_icache_miss,
  input  logic [NUM_CORES-1:0]   core_icache_fill,
  input  logic [NUM_CORES-1:0]   core_dcache_req,
  input  logic [NUM_CORES-1:0]   core_dcache_hit,
  input  logic [NUM_CORES-1:0]   core_dcache_fill,
  abacus_trace_hub_if.master     trace,
  input  logic                   cnt_clear,
  input  logic [CORE_W-1:0]      cnt_core_sel,
  input  logic [2:0]             cnt_event_sel,
  output logic [CNT_W-1:0]       cnt_value
);

  if (NUM_CORES < 1) begin : g_bad_cores
    $error("abacus_trace_hub: NUM_CORES must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("abacus_trace_hub: FIFO_DEPTH must be a power of two >= 2");
  end
  if (CNT_W < 8 || CNT_W > 64) begin : g_bad_cnt
    $error("abacus_trace_hub: CNT_W must be 8..64");
  end
  if (TS_W < 1 || TS_W > ABACUS_TS_W) begin : g_bad_ts
    $error("abacus_trace_hub: TS_W must be 1..ABACUS_TS_W");
  end

  logic [NUM_CORES-1:0] push_req;
  logic [NUM_CORES-1:0] fifo_pop;
  logic [NUM_CORES-1:0] fifo_full;
  logic [NUM_CORES-1:0] fifo_empty;
  logic [NUM_CORES-1:0] fifo_drop;
  abacus_trace_entry_t  fifo_head [NUM_CORES];

  logic                 out_valid;
  logic [CORE_W-1:0]    out_core;
  abacus_trace_entry_t  out_entry;
  logic [CORE_W-1:0]    rr_ptr;
  logic                 load;
  logic                 grant_found;
  logic [CORE_W-1:0]    grant_idx;
  logic [CORE_W-1:0]    cand;

  logic [ABACUS_NUM_EVENTS-1:0] ev [NUM_CORES];
  logic [CNT_W-1:0]     cnt [NUM_CORES][ABACUS_NUM_EVENTS];
  logic [CNT_W-1:0]     cnt_sel_val;

  assign push_req  = {NUM_CORES{enable}} & core_issued;
  assign fifo_drop = push_req & fifo_full & ~fifo_pop;
  assign load      = !out_valid || trace.trace_ready;

`ifdef ABACUS_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running cycle counter; each entry captures its value at push time.
  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + TS_W'(1);
  end

  assign trace.trace_timestamp = TS_W'(out_entry.timestamp);
`endif

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    abacus_trace_entry_t push_entry;

    // Build the entry stored for this core's issued instruction.
    always_comb begin
      push_entry             = '0;
      push_entry.instruction = core_instruction[32*g +: 32];
`ifdef ABACUS_TRACE_TIMESTAMP_EN
      push_entry.timestamp   = ABACUS_TS_W'(ts_cnt);
`endif
    end

    abacus_trace_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W ($bits(abacus_trace_entry_t))
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req[g]),
      .push_data (push_entry),
      .pop       (fifo_pop[g]),
      .head      (fifo_head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  // Round-robin search: first non-empty FIFO at or after the pointer wins, and is popped on load.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    fifo_pop    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = CORE_W'((int'(rr_ptr) + k) % NUM_CORES);
      if (!grant_found && !fifo_empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    if (load && grant_found) fifo_pop[grant_idx] = 1'b1;
  end

  // Output register holds its record until accepted; the pointer moves just past the granted core.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_core  <= '0;
      out_entry <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= grant_found;
      if (grant_found) begin
        out_core  <= grant_idx;
        out_entry <= fifo_head[grant_idx];
        rr_ptr    <= CORE_W'((int'(grant_idx) + 1) % NUM_CORES);
      end
    end
  end

  assign trace.trace_valid       = out_valid;
  assign trace.trace_core_id     = out_core;
  assign trace.trace_instruction = out_entry.instruction;

  // Gather each core's per-cycle event strobes in event-number order.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      ev[i]                     = '0;
      ev[i][EV_ISSUED]          = core_issued[i];
      ev[i][EV_ICACHE_REQ]      = core_icache_req[i];
      ev[i][EV_ICACHE_MISS]     = core_icache_miss[i];
      ev[i][EV_ICACHE_FILL_CYC] = core_icache_fill[i];
      ev[i][EV_DCACHE_REQ]      = core_dcache_req[i];
      ev[i][EV_DCACHE_HIT]      = core_dcache_hit[i];
      ev[i][EV_DCACHE_FILL_CYC] = core_dcache_fill[i];
      ev[i][EV_TRACE_DROP]      = fifo_drop[i];
    end
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      for (int e = 0; e < ABACUS_NUM_EVENTS; e++) begin
        if (rst || cnt_clear) begin
          cnt[i][e] <= '0;
        end else if (enable && ev[i][e] && (cnt[i][e] != '1)) begin
          cnt[i][e] <= cnt[i][e] + CNT_W'(1);
        end
      end
    end
  end

  // Select the requested counter; a core index with no core behind it reads 0.
  always_comb begin
    cnt_sel_val = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (cnt_core_sel == CORE_W'(i)) cnt_sel_val = cnt[i][cnt_event_sel];
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) cnt_value <= '0;
    else     cnt_value <= cnt_sel_val;
  end

endmodule

// File: tb/tb_abacus_trace_hub.sv
// Self-checking bench for abacus_trace_hub (4 cores, 4-deep FIFOs, 8-bit counters).
// Expected trace records are queued when issues are driven and compared as records are accepted.
module tb_abacus_trace_hub;
  import abacus_pkg::*;

  localparam int NC     = 4;
  localparam int DEPTH  = 4;
  localparam int CW     = 8;
  localparam int CORE_W = 2;

  typedef struct packed {
    logic [CORE_W-1:0] core;
    logic [31:0]       instr;
  } exp_rec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [NC*32-1:0]  core_instruction;
  logic [NC-1:0]     core_issued;
  logic [NC-1:0]     core_icache_req;
  logic [NC-1:0]     core_icache_miss;
  logic [NC-1:0]     core_icache_fill;
  logic [NC-1:0]     core_dcache_req;
  logic [NC-1:0]     core_dcache_hit;
  logic [NC-1:0]     core_dcache_fill;
  logic              cnt_clear;
  logic [CORE_W-1:0] cnt_core_sel;
  logic [2:0]        cnt_event_sel;
  logic [CW-1:0]     cnt_value;

  exp_rec_t          exp_q[$];
  logic [NC*32-1:0]  stim_vec;
  logic [CW-1:0]     rd_val;
  int                check_count = 0;
  int                error_count = 0;

  abacus_trace_hub_if #(.CORE_W(CORE_W), .TS_W(32)) trace_if ();

  abacus_trace_hub #(
    .NUM_CORES  (NC),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW),
    .TS_W       (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .core_instruction (core_instruction),
    .core_issued      (core_issued),
    .core_icache_req  (core_icache_req),
    .core_icache_miss (core_icache_miss),
    .core_icache_fill (core_icache_fill),
    .core_dcache_req  (core_dcache_req),
    .core_dcache_hit  (core_dcache_hit),
    .core_dcache_fill (core_dcache_fill),
    .trace            (trace_if),
    .cnt_clear        (cnt_clear),
    .cnt_core_sel     (cnt_core_sel),
    .cnt_event_sel    (cnt_event_sel),
    .cnt_value        (cnt_value)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst              = 1'b1;
    core_issued      = '0;
    core_icache_req  = '0;
    core_icache_miss = '0;
    core_icache_fill = '0;
    core_dcache_req  = '0;
    core_dcache_hit  = '0;
    core_dcache_fill = '0;
    cnt_clear        = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic applyStimulus(input logic [NC-1:0] issued, input logic [NC*32-1:0] instr);
    core_issued      = issued;
    core_instruction = instr;
    tick();
    core_issued      = '0;
  endtask

  task automatic checkCounter(input string tag, input logic [CORE_W-1:0] core,
                              input logic [2:0] event_sel, input logic [CW-1:0] expected);
    cnt_core_sel  = core;
    cnt_event_sel = event_sel;
    tick();
    checkOutput(tag, cnt_value, expected);
  endtask

  task automatic waitDrain(input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) tick();
    checkOutput("drain_done", exp_q.size(), 0);
  endtask

  // Scoreboard: every accepted record must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && trace_if.trace_valid && trace_if.trace_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_pending", exp_q.size(), 1);
      end else begin
        exp_rec_t rec;
        rec = exp_q.pop_front();
        checkOutput("rec_core", trace_if.trace_core_id, rec.core);
        checkOutput("rec_instr", trace_if.trace_instruction, rec.instr);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    enable                = 1'b1;
    core_instruction      = '0;
    cnt_core_sel          = '0;
    cnt_event_sel         = '0;
    trace_if.trace_ready  = 1'b0;
    doReset();

    // Reset state
    checkOutput("rst_valid", trace_if.trace_valid, 0);
    checkOutput("rst_core", trace_if.trace_core_id, 0);
    checkOutput("rst_instr", trace_if.trace_instruction, 0);
    checkOutput("rst_cnt", cnt_value, 0);

    // Two cores issue together: core0 record 2 cycles later, core1 next
    $display("[TB] simultaneous issue on cores 0 and 1");
    trace_if.trace_ready = 1'b1;
    exp_q.push_back('{core: 2'd0, instr: 32'h0000_0013});
    exp_q.push_back('{core: 2'd1, instr: 32'h0010_0093});
    stim_vec = '0;
    stim_vec[31:0]  = 32'h0000_0013;
    stim_vec[63:32] = 32'h0010_0093;
    applyStimulus(4'b0011, stim_vec);
    checkOutput("lat_early", trace_if.trace_valid, 0);
    tick();
    checkOutput("lat_valid", trace_if.trace_valid, 1);
    checkOutput("lat_core", trace_if.trace_core_id, 0);
    waitDrain(10);
    checkOutput("idle_valid", trace_if.trace_valid, 0);

    // Stall with ready low: 1 in output reg, 4 buffered, 1 dropped
    $display("[TB] fill and drop on core 0");
    doReset();
    trace_if.trace_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) exp_q.push_back('{core: 2'd0, instr: 32'hA000_0000 + 32'(k)});
      stim_vec = '0;
      stim_vec[31:0] = 32'hA000_0000 + 32'(k);
      applyStimulus(4'b0001, stim_vec);
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput("hold_valid", trace_if.trace_valid, 1);
      checkOutput("hold_core", trace_if.trace_core_id, 0);
      checkOutput("hold_instr", trace_if.trace_instruction, 32'hA000_0000);
      tick();
    end
    checkCounter("issued0", 2'd0, EV_ISSUED, 8'd6);
    checkCounter("drop0", 2'd0, EV_TRACE_DROP, 8'd1);
    checkCounter("issued1", 2'd1, EV_ISSUED, 8'd0);
    trace_if.trace_ready = 1'b1;
    tick();
    trace_if.trace_ready = 1'b0;
    checkOutput("one_pop_valid", trace_if.trace_valid, 1);
    checkOutput("one_pop_instr", trace_if.trace_instruction, 32'hA000_0001);
    checkOutput("one_pop_left", exp_q.size(), 4);
    trace_if.trace_ready = 1'b1;
    waitDrain(20);
    checkOutput("drained_valid", trace_if.trace_valid, 0);

    // Each event input maps to its own counter; core3 event n is held n cycles
    $display("[TB] event mapping and enable gating");
    doReset();
    for (int c = 0; c < 6; c++) begin
      core_icache_req[3]  = (c < 1);
      core_icache_miss[3] = (c < 2);
      core_icache_fill[3] = (c < 3);
      core_dcache_req[3]  = (c < 4);
      core_dcache_hit[3]  = (c < 5);
      core_dcache_fill[3] = (c < 6);
      tick();
    end
    core_icache_req  = '0;
    core_icache_miss = '0;
    core_icache_fill = '0;
    core_dcache_req  = '0;
    core_dcache_hit  = '0;
    core_dcache_fill = '0;
    checkCounter("ev_icache_req", 2'd3, EV_ICACHE_REQ, 8'd1);
    checkCounter("ev_icache_miss", 2'd3, EV_ICACHE_MISS, 8'd2);
    checkCounter("ev_icache_fill", 2'd3, EV_ICACHE_FILL_CYC, 8'd3);
    checkCounter("ev_dcache_req", 2'd3, EV_DCACHE_REQ, 8'd4);
    checkCounter("ev_dcache_hit", 2'd3, EV_DCACHE_HIT, 8'd5);
    checkCounter("ev_dcache_fill", 2'd3, EV_DCACHE_FILL_CYC, 8'd6);
    checkCounter("ev_other_core", 2'd0, EV_ICACHE_REQ, 8'd0);
    enable = 1'b0;
    stim_vec = '0;
    stim_vec[95:64] = 32'h0000_0033;
    core_icache_req = 4'b1111;
    core_issued     = 4'b0100;
    core_instruction = stim_vec;
    repeat (3) tick();
    core_issued     = '0;
    core_icache_req = '0;
    enable = 1'b1;
    checkOutput("dis_valid", trace_if.trace_valid, 0);
    checkCounter("dis_issued2", 2'd2, EV_ISSUED, 8'd0);
    checkCounter("dis_icache3", 2'd3, EV_ICACHE_REQ, 8'd1);

    // Saturation at 255 and clear priority
    $display("[TB] counter saturation and clear");
    doReset();
    core_icache_miss[1] = 1'b1;
    repeat (300) tick();
    checkCounter("sat_miss1", 2'd1, EV_ICACHE_MISS, 8'd255);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    tick();
    checkOutput("clear_read0", cnt_value, 0);
    tick();
    checkOutput("clear_read1", cnt_value, 1);
    core_icache_miss = '0;

    // All four cores issue: grants rotate 0,1,2,3,0,...
    $display("[TB] round-robin across four cores");
    doReset();
    trace_if.trace_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < NC; c++) begin
        exp_q.push_back('{core: CORE_W'(c), instr: (32'(c) << 24) | 32'(s)});
      end
    end
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < NC; c++) stim_vec[32*c +: 32] = (32'(c) << 24) | 32'(s);
      applyStimulus(4'b1111, stim_vec);
    end
    waitDrain(40);

    // Reset with records buffered discards them
    $display("[TB] reset mid-stream");
    doReset();
    trace_if.trace_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stim_vec = '0;
      stim_vec[63:32] = 32'hB000_0000 + 32'(k);
      applyStimulus(4'b0010, stim_vec);
    end
    tick();
    checkOutput("pre_rst_valid", trace_if.trace_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checkOutput("mid_rst_valid", trace_if.trace_valid, 0);
    checkOutput("mid_rst_instr", trace_if.trace_instruction, 0);
    trace_if.trace_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("post_rst_valid", trace_if.trace_valid, 0);
    end
    checkCounter("post_rst_issued1", 2'd1, EV_ISSUED, 8'd0);

`ifdef ABACUS_TRACE_TIMESTAMP_EN
    // Timestamp equals the cycle count at push: reset released, then 3 idle cycles
    $display("[TB] timestamp capture");
    doReset();
    trace_if.trace_ready = 1'b0;
    repeat (3) tick();
    stim_vec = '0;
    stim_vec[31:0] = 32'hC000_0000;
    applyStimulus(4'b0001, stim_vec);
    tick();
    checkOutput("ts_valid", trace_if.trace_valid, 1);
    checkOutput("ts_value", trace_if.trace_timestamp, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
